sentry_md_result_buffer: RTL and testbench
==========================================

SENTRY_MD_RESULT_BUFFER -- requirements
Module: sentry_md_result_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, giving the number of result entries; power of two, 2..64.
REQ-002 SHALL have parameter CNT_W, default $clog2(DEPTH+1), giving the width of the occupancy and credit counters.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: the reset; synchronous and active-high.
REQ-005 SHALL have port issue, input, 1 bit: the operand stage fires one request into the muldiv unit this cycle.
REQ-006 SHALL have port issue_ok, output, 1 bit: a result slot is reserved and available for a new request.
REQ-007 SHALL have port md_done, input, 1 bit: the muldiv unit produces a result this cycle; single-cycle pulse, no backpressure.
REQ-008 SHALL have port md_out, input, data_t (64 bits): the muldiv result, valid when md_done=1.
REQ-009 SHALL have port res_valid, output, 1 bit: the head entry is available to the consumer.
REQ-010 SHALL have port res_ready, input, 1 bit: the consumer accepts the head entry.
REQ-011 SHALL have port res_data, output, data_t: the head entry data.
REQ-012 SHALL have port occupancy, output, CNT_W bits: the number of entries stored.
REQ-013 SHALL have port in_flight, output, CNT_W bits: the number of issued requests whose result has not yet been popped.
REQ-014 SHALL have port err, output, 2 bits, sticky: bit0 = issue while !issue_ok; bit1 = md_done with no request outstanding, or md_done while the buffer is full.

Function
REQ-015 SHALL buffer results in a circular buffer with wr_ptr and rd_ptr, each log2(DEPTH) bits, which wrap modulo DEPTH.
REQ-016 SHALL push md_out at wr_ptr on md_done; the push is suppressed when the buffer is full, when no request is outstanding (in_flight==occupancy), or during rst.
REQ-017 SHALL pop the head entry on res_valid && res_ready; rd_ptr increments and occupancy decrements.
REQ-018 SHALL drive res_valid = (occupancy != 0) and res_data = mem[rd_ptr], both from registered state.
REQ-019 SHALL make latency 1 cycle from md_done to res_valid, with no combinational bypass from md_done or md_out to the outputs.
REQ-020 SHALL, on a simultaneous push and pop, apply both: occupancy unchanged, both pointers advance; when empty, the push is accepted and no pop occurs.
REQ-021 SHALL drive issue_ok = !rst && (in_flight < DEPTH), so every issued request is guaranteed a slot.
REQ-022 SHALL increment in_flight on issue && issue_ok, and decrement it on a pop.
REQ-023 SHALL, on a simultaneous issue and pop, leave in_flight unchanged.
REQ-024 SHALL ignore issue while !issue_ok: in_flight is not incremented and err[0] is set.
REQ-025 SHALL set err[1] on any suppressed md_done and drop that data.
REQ-026 SHALL keep err bits set until rst.
REQ-027 SHALL hold res_data stable while res_valid=1 && res_ready=0.
REQ-028 SHALL maintain the invariant occupancy <= in_flight <= DEPTH in all cycles.

Reset
REQ-029 SHALL, when rst=1 at a clock edge, clear wr_ptr, rd_ptr, occupancy, in_flight and err to 0.
REQ-030 SHALL drive res_valid=0, issue_ok=0, occupancy=0 and in_flight=0 in the cycle after rst; res_data is don't-care.
REQ-031 SHALL, on rst asserted mid-operation, discard all buffered entries and in-flight credits; a md_done in the same cycle as rst is dropped without setting err.
REQ-032 SHALL assert issue_ok in the first cycle after rst deasserts.

Verification
REQ-033 SHALL be covered by: rst, then issue x1, md_done with md_out=0x1234 two cycles later -> res_valid=1 the next cycle, res_data=0x1234, occupancy=1, in_flight=1; then pop -> both counters 0.
REQ-034 SHALL be covered by: DEPTH=8, issue 8 back-to-back -> issue_ok=0 after the 8th; a 9th issue sets err=2'b01 and in_flight stays 8.
REQ-035 SHALL be covered by: 8 results pushed with res_ready=0 -> occupancy=8 and res_data held at the first value; then res_ready=1 for 8 cycles -> values pop in FIFO order, and pointers wrap to 0.
REQ-036 SHALL be covered by: occupancy=3 with simultaneous md_done, pop and issue -> occupancy stays 3, in_flight unchanged, data order preserved.
REQ-037 SHALL be covered by: md_done with in_flight=0 -> no push, err=2'b10, res_valid stays 0.
REQ-038 SHALL be covered by: rst asserted with occupancy=5 and in_flight=7 -> next cycle all counters 0, res_valid=0; the following cycle issue_ok=1.

Source files
------------

// File: rtl/sentry_md_result_buffer.sv
`default_nettype none
// ============================================================================
// Module      : sentry_md_result_buffer
// Description : Credit-based result buffer between the muldiv unit and its
//               consumer. Issue credits (in_flight) reserve a slot for every
//               request, so the muldiv unit never sees backpressure. Results
//               are held in a circular buffer and presented in FIFO order.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               issue / issue_ok   - request fire / slot-available credit
//               md_done / md_out   - muldiv result strobe and 64-bit data
//               res_valid / res_ready / res_data - result handshake (head)
//               occupancy          - entries stored
//               in_flight          - issued requests not yet popped
//               err                - sticky: [0] bad issue, [1] dropped result
// Revision    : 1.0 - initial release
// ============================================================================
module sentry_md_result_buffer #(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue,
    output logic             issue_ok,
    input  logic             md_done,
    input  logic [63:0]      md_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [63:0]      res_data,
    output logic [CNT_W-1:0] occupancy,
    output logic [CNT_W-1:0] in_flight,
    output logic [1:0]       err
);

    localparam int               c_PTR_W     = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] c_DEPTH_CNT = CNT_W'(DEPTH);

    logic [c_PTR_W-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [c_PTR_W-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [CNT_W-1:0]   r_occ_q,    w_occ_d;
    logic [CNT_W-1:0]   r_infl_q,   w_infl_d;
    logic [1:0]         r_err_q,    w_err_d;
    logic [63:0]        r_mem [DEPTH];

    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_issue_ok;
    logic w_issue_acc;

    always_comb begin
        w_full      = (r_occ_q == c_DEPTH_CNT);
        w_issue_ok  = !rst && (r_infl_q < c_DEPTH_CNT);
        w_issue_acc = issue && w_issue_ok;
        w_pop       = (r_occ_q != '0) && res_ready;
        // A result is only legitimate when a credit exists beyond what is
        // already stored; otherwise it is dropped and flagged.
        w_push      = md_done && !rst && !w_full && (r_infl_q != r_occ_q);
    end

    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_occ_d    = r_occ_q;
        w_infl_d   = r_infl_q;
        w_err_d    = r_err_q;

        if (w_push) w_wr_ptr_d = r_wr_ptr_q + c_PTR_W'(1);
        if (w_pop)  w_rd_ptr_d = r_rd_ptr_q + c_PTR_W'(1);

        case ({w_push, w_pop})
            2'b10:   w_occ_d = r_occ_q + CNT_W'(1);
            2'b01:   w_occ_d = r_occ_q - CNT_W'(1);
            default: w_occ_d = r_occ_q;
        endcase

        case ({w_issue_acc, w_pop})
            2'b10:   w_infl_d = r_infl_q + CNT_W'(1);
            2'b01:   w_infl_d = r_infl_q - CNT_W'(1);
            default: w_infl_d = r_infl_q;
        endcase

        if (issue && !w_issue_ok)            w_err_d[0] = 1'b1;
        if (md_done && !w_push && !rst)      w_err_d[1] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_occ_q    <= '0;
            r_infl_q   <= '0;
            r_err_q    <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_occ_q    <= w_occ_d;
            r_infl_q   <= w_infl_d;
            r_err_q    <= w_err_d;
        end
    end

    // Storage needs no reset: entries are only visible while occupancy != 0.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr_q] <= md_out;
    end

    always_comb begin
        issue_ok  = w_issue_ok;
        res_valid = (r_occ_q != '0);
        res_data  = r_mem[r_rd_ptr_q];
        occupancy = r_occ_q;
        in_flight = r_infl_q;
        err       = r_err_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_sentry_md_result_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sentry_md_result_buffer
// Description : Directed self-checking bench for sentry_md_result_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sentry_md_result_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue;
    logic        issue_ok;
    logic        md_done;
    logic [63:0] md_out;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] res_data;
    logic [3:0]  occupancy;
    logic [3:0]  in_flight;
    logic [1:0]  err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sentry_md_result_buffer #(.DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .issue     (issue),
        .issue_ok  (issue_ok),
        .md_done   (md_done),
        .md_out    (md_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .occupancy (occupancy),
        .in_flight (in_flight),
        .err       (err)
    );

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; issue = 1'b0; md_done = 1'b0; res_ready = 1'b0; md_out = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; issue = 1'b0; md_done = 1'b0; res_ready = 1'b0; md_out = '0;
        tick(); tick();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b exp 0", res_valid); end
        checks++; if (issue_ok !== 1'b0) begin errors++; $display("FAIL reset_issue_ok: got %b exp 0", issue_ok); end
        checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL reset_occ: got %0d exp 0", occupancy); end
        checks++; if (in_flight !== 4'd0) begin errors++; $display("FAIL reset_infl: got %0d exp 0", in_flight); end
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL reset_err: got %b exp 00", err); end
        rst = 1'b0;
        #1;
        checks++; if (issue_ok !== 1'b1) begin errors++; $display("FAIL reset_release_issue_ok: got %b exp 1", issue_ok); end
    endtask

    task automatic test_single();
        issue = 1'b1; tick(); issue = 1'b0;
        checks++; if (in_flight !== 4'd1) begin errors++; $display("FAIL single_infl_issue: got %0d exp 1", in_flight); end
        tick();
        md_done = 1'b1; md_out = 64'h1234;
        #1;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_no_bypass: got %b exp 0", res_valid); end
        tick(); md_done = 1'b0;
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL single_res_valid: got %b exp 1", res_valid); end
        checks++; if (res_data !== 64'h1234) begin errors++; $display("FAIL single_res_data: got %h exp 1234", res_data); end
        checks++; if (occupancy !== 4'd1) begin errors++; $display("FAIL single_occ: got %0d exp 1", occupancy); end
        checks++; if (in_flight !== 4'd1) begin errors++; $display("FAIL single_infl: got %0d exp 1", in_flight); end
        res_ready = 1'b1; tick(); res_ready = 1'b0;
        checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL single_pop_occ: got %0d exp 0", occupancy); end
        checks++; if (in_flight !== 4'd0) begin errors++; $display("FAIL single_pop_infl: got %0d exp 0", in_flight); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid: got %b exp 0", res_valid); end
    endtask

    task automatic test_full_credits();
        issue = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        checks++; if (issue_ok !== 1'b0) begin errors++; $display("FAIL full_issue_ok: got %b exp 0", issue_ok); end
        checks++; if (in_flight !== 4'd8) begin errors++; $display("FAIL full_infl: got %0d exp 8", in_flight); end
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL full_err_before: got %b exp 00", err); end
        tick(); issue = 1'b0;
        checks++; if (err !== 2'b01) begin errors++; $display("FAIL full_err_9th: got %b exp 01", err); end
        checks++; if (in_flight !== 4'd8) begin errors++; $display("FAIL full_infl_9th: got %0d exp 8", in_flight); end
    endtask

    // Continues from 8 credits outstanding; pointers start at 1 and wrap.
    task automatic test_fifo_wrap();
        md_done = 1'b1;
        for (int i = 0; i < 8; i++) begin
            md_out = 64'hA000 + 64'(i);
            tick();
        end
        md_done = 1'b0;
        checks++; if (occupancy !== 4'd8) begin errors++; $display("FAIL wrap_occ: got %0d exp 8", occupancy); end
        checks++; if (res_data !== 64'hA000) begin errors++; $display("FAIL wrap_head: got %h exp a000", res_data); end
        // Result arriving while full is dropped and flagged.
        md_done = 1'b1; md_out = 64'hDEAD; tick(); md_done = 1'b0;
        checks++; if (err !== 2'b11) begin errors++; $display("FAIL wrap_full_err: got %b exp 11", err); end
        checks++; if (occupancy !== 4'd8) begin errors++; $display("FAIL wrap_full_occ: got %0d exp 8", occupancy); end
        tick();
        checks++; if (res_data !== 64'hA000) begin errors++; $display("FAIL wrap_hold: got %h exp a000", res_data); end
        res_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (res_data !== 64'hA000 + 64'(i)) begin errors++; $display("FAIL wrap_order[%0d]: got %h exp %h", i, res_data, 64'hA000 + 64'(i)); end
            tick();
        end
        res_ready = 1'b0;
        checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL wrap_drain_occ: got %0d exp 0", occupancy); end
        checks++; if (in_flight !== 4'd0) begin errors++; $display("FAIL wrap_drain_infl: got %0d exp 0", in_flight); end
        checks++; if (err !== 2'b11) begin errors++; $display("FAIL wrap_err_sticky: got %b exp 11", err); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        issue = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        issue = 1'b0; md_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            md_out = 64'hB000 + 64'(i);
            tick();
        end
        checks++; if (occupancy !== 4'd3) begin errors++; $display("FAIL simul_pre_occ: got %0d exp 3", occupancy); end
        md_out = 64'hB003; res_ready = 1'b1; issue = 1'b1;
        tick();
        md_done = 1'b0; issue = 1'b0;
        checks++; if (occupancy !== 4'd3) begin errors++; $display("FAIL simul_occ: got %0d exp 3", occupancy); end
        checks++; if (in_flight !== 4'd5) begin errors++; $display("FAIL simul_infl: got %0d exp 5", in_flight); end
        for (int i = 1; i < 4; i++) begin
            checks++; if (res_data !== 64'hB000 + 64'(i)) begin errors++; $display("FAIL simul_order[%0d]: got %h exp %h", i, res_data, 64'hB000 + 64'(i)); end
            tick();
        end
        res_ready = 1'b0;
        checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL simul_drain_occ: got %0d exp 0", occupancy); end
        checks++; if (in_flight !== 4'd2) begin errors++; $display("FAIL simul_drain_infl: got %0d exp 2", in_flight); end
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL simul_err: got %b exp 00", err); end
    endtask

    task automatic test_orphan();
        do_reset();
        md_done = 1'b1; md_out = 64'h5555; tick(); md_done = 1'b0;
        checks++; if (err !== 2'b10) begin errors++; $display("FAIL orphan_err: got %b exp 10", err); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL orphan_valid: got %b exp 0", res_valid); end
        checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL orphan_occ: got %0d exp 0", occupancy); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        issue = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        issue = 1'b0; md_done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            md_out = 64'hC000 + 64'(i);
            tick();
        end
        md_done = 1'b0;
        checks++; if (occupancy !== 4'd5) begin errors++; $display("FAIL midrst_pre_occ: got %0d exp 5", occupancy); end
        checks++; if (in_flight !== 4'd7) begin errors++; $display("FAIL midrst_pre_infl: got %0d exp 7", in_flight); end
        rst = 1'b1; md_done = 1'b1; md_out = 64'hFFFF;
        tick();
        md_done = 1'b0;
        checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL midrst_occ: got %0d exp 0", occupancy); end
        checks++; if (in_flight !== 4'd0) begin errors++; $display("FAIL midrst_infl: got %0d exp 0", in_flight); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b exp 0", res_valid); end
        checks++; if (issue_ok !== 1'b0) begin errors++; $display("FAIL midrst_issue_ok: got %b exp 0", issue_ok); end
        rst = 1'b0;
        tick();
        checks++; if (issue_ok !== 1'b1) begin errors++; $display("FAIL midrst_issue_ok_after: got %b exp 1", issue_ok); end
        checks++; if (err !== 2'b00) begin errors++; $display("FAIL midrst_err: got %b exp 00", err); end
        checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL midrst_occ_after: got %0d exp 0", occupancy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_credits();
        test_fifo_wrap();
        test_simultaneous();
        test_orphan();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
